// File: rtl/conv_sched_pkg.sv
// Shared phase encoding and defaults for the conv tile scheduler and its engines.
// Optional watchdog is enabled with the SCHED_TIMEOUT_EN macro.
package conv_sched_pkg;

  localparam logic [2:0] PH_IDLE = 3'd0;
  localparam logic [2:0] PH_LOAD = 3'd1;
  localparam logic [2:0] PH_COMP = 3'd2;
  localparam logic [2:0] PH_WB   = 3'd3;

  localparam int DEF_ROW_W = 10;
  localparam int DEF_CH_W  = 8;
  localparam int DEF_TO_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE = PH_IDLE,
    S_LOAD = PH_LOAD,
    S_COMP = PH_COMP,
    S_WB   = PH_WB
  } phase_e;

  function automatic logic is_active(input phase_e ph);
    return (ph == S_LOAD) || (ph == S_COMP) || (ph == S_WB);
  endfunction

endpackage

// File: rtl/conv_tile_sched_if.sv
// Handshake bundle between the layer controller / engines and the tile scheduler.
// The to_limit signal exists only when SCHED_TIMEOUT_EN is defined.
interface conv_tile_sched_if
  import conv_sched_pkg::*;
#(
  parameter int ROW_W = DEF_ROW_W,
  parameter int CH_W  = DEF_CH_W
`ifdef SCHED_TIMEOUT_EN
  , parameter int TO_W = DEF_TO_W
`endif
);
  logic             start;
  logic             abort;
  logic [ROW_W-1:0] cfg_rows;
  logic [CH_W-1:0]  cfg_ch;
  logic             ld_end;
  logic             comp_end;
  logic             wb_end;
`ifdef SCHED_TIMEOUT_EN
  logic [TO_W-1:0]  to_limit;
`endif
  logic [2:0]       phase;
  logic             ld_go;
  logic             comp_go;
  logic             wb_go;
  logic [ROW_W-1:0] row_idx;
  logic [CH_W-1:0]  ch_idx;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
`ifdef SCHED_TIMEOUT_EN
    output to_limit,
`endif
    output start, abort, cfg_rows, cfg_ch, ld_end, comp_end, wb_end,
    input  phase, ld_go, comp_go, wb_go, row_idx, ch_idx, busy, done, err
  );

  modport slave (
`ifdef SCHED_TIMEOUT_EN
    input  to_limit,
`endif
    input  start, abort, cfg_rows, cfg_ch, ld_end, comp_end, wb_end,
    output phase, ld_go, comp_go, wb_go, row_idx, ch_idx, busy, done, err
  );
endinterface

// File: rtl/conv_sched_idx.sv
// Row/channel nested pass counter: latches the job size on load, channel is the inner loop.
module conv_sched_idx #(
  parameter int ROW_W = 10,
  parameter int CH_W  = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             load_i,
  input  logic [ROW_W-1:0] cfg_rows_i,
  input  logic [CH_W-1:0]  cfg_ch_i,
  input  logic             advance_i,
  output logic [ROW_W-1:0] row_idx_o,
  output logic [CH_W-1:0]  ch_idx_o,
  output logic             last_o
);
  logic [ROW_W-1:0] rows_q, rows_d, row_q, row_d;
  logic [CH_W-1:0]  chs_q, chs_d, ch_q, ch_d;
  logic             ch_last, row_last;

  // One extra bit so count-1 compares cleanly at the maximum counts.
  assign ch_last  = ({1'b0, ch_q} + (CH_W+1)'(1)) == {1'b0, chs_q};
  assign row_last = ({1'b0, row_q} + (ROW_W+1)'(1)) == {1'b0, rows_q};
  assign last_o   = ch_last && row_last;

  always_comb begin
    rows_d = rows_q;
    chs_d  = chs_q;
    row_d  = row_q;
    ch_d   = ch_q;
    if (load_i) begin
      rows_d = cfg_rows_i;
      chs_d  = cfg_ch_i;
      row_d  = '0;
      ch_d   = '0;
    end else if (advance_i) begin
      if (ch_last) begin
        ch_d  = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        ch_d  = ch_q + CH_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rows_q <= '0;
      chs_q  <= '0;
      row_q  <= '0;
      ch_q   <= '0;
    end else begin
      rows_q <= rows_d;
      chs_q  <= chs_d;
      row_q  <= row_d;
      ch_q   <= ch_d;
    end
  end

  assign row_idx_o = row_q;
  assign ch_idx_o  = ch_q;
endmodule

// File: rtl/conv_tile_sched.sv
// Tile scheduler: walks rows x channels passes through LOAD/COMP/WB with registered go pulses.
// Define SCHED_TIMEOUT_EN to add the per-phase watchdog (to_limit input, sticky err).
module conv_tile_sched
  import conv_sched_pkg::*;
#(
  parameter int ROW_W = DEF_ROW_W,
  parameter int CH_W  = DEF_CH_W
`ifdef SCHED_TIMEOUT_EN
  , parameter int TO_W = DEF_TO_W
`endif
) (
  input logic               clk,
  input logic               rstn,
  conv_tile_sched_if.slave  bus
);
  phase_e           phase_q, phase_d;
  logic             ld_go_q, ld_go_d, comp_go_q, comp_go_d, wb_go_q, wb_go_d;
  logic             done_q, done_d;
  logic             idx_load, idx_adv, idx_last;
  logic             cfg_zero, end_hit, timeout, to_fire;
  logic [ROW_W-1:0] row_idx;
  logic [CH_W-1:0]  ch_idx;

  conv_sched_idx #(.ROW_W(ROW_W), .CH_W(CH_W)) u_idx (
    .clk        (clk),
    .rstn       (rstn),
    .load_i     (idx_load),
    .cfg_rows_i (bus.cfg_rows),
    .cfg_ch_i   (bus.cfg_ch),
    .advance_i  (idx_adv),
    .row_idx_o  (row_idx),
    .ch_idx_o   (ch_idx),
    .last_o     (idx_last)
  );

  assign cfg_zero = (bus.cfg_rows == '0) || (bus.cfg_ch == '0);

  always_comb begin
    end_hit = 1'b0;
    case (phase_q)
      S_LOAD:  end_hit = bus.ld_end;
      S_COMP:  end_hit = bus.comp_end;
      S_WB:    end_hit = bus.wb_end;
      default: end_hit = 1'b0;
    endcase
  end

  assign to_fire = timeout && !end_hit;

  always_comb begin
    phase_d  = phase_q;
    done_d   = 1'b0;
    idx_load = 1'b0;
    idx_adv  = 1'b0;
    if (bus.abort) begin
      phase_d = S_IDLE;
    end else begin
      case (phase_q)
        S_IDLE: if (bus.start) begin
          idx_load = 1'b1;
          if (cfg_zero) done_d  = 1'b1;
          else          phase_d = S_LOAD;
        end
        S_LOAD: if (end_hit) phase_d = S_COMP;
                else if (to_fire) phase_d = S_IDLE;
        S_COMP: if (end_hit) phase_d = S_WB;
                else if (to_fire) phase_d = S_IDLE;
        S_WB: if (end_hit) begin
          if (idx_last) begin
            phase_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            phase_d = S_LOAD;
            idx_adv = 1'b1;
          end
        end else if (to_fire) begin
          phase_d = S_IDLE;
        end
        default: phase_d = S_IDLE;
      endcase
    end
    // A go pulse marks phase entry, so it can never coincide with done.
    ld_go_d   = (phase_d == S_LOAD) && (phase_q != S_LOAD);
    comp_go_d = (phase_d == S_COMP) && (phase_q != S_COMP);
    wb_go_d   = (phase_d == S_WB)   && (phase_q != S_WB);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      phase_q   <= S_IDLE;
      ld_go_q   <= 1'b0;
      comp_go_q <= 1'b0;
      wb_go_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      ld_go_q   <= ld_go_d;
      comp_go_q <= comp_go_d;
      wb_go_q   <= wb_go_d;
      done_q    <= done_d;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  // cnt_q counts cycles already spent in the phase; fire on the to_limit-th cycle.
  assign timeout = (bus.to_limit != '0) &&
                   (({1'b0, cnt_q} + (TO_W+1)'(1)) == {1'b0, bus.to_limit});

  always_comb begin
    cnt_d = '0;
    if (phase_d == phase_q) cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + TO_W'(1);
    err_d = err_q;
    if (idx_load)                                              err_d = 1'b0;
    else if (!bus.abort && is_active(phase_q) && to_fire)      err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign timeout = 1'b0;
  assign bus.err = 1'b0;
`endif

  assign bus.phase   = phase_q;
  assign bus.busy    = (phase_q != S_IDLE);
  assign bus.ld_go   = ld_go_q;
  assign bus.comp_go = comp_go_q;
  assign bus.wb_go   = wb_go_q;
  assign bus.done    = done_q;
  assign bus.row_idx = row_idx;
  assign bus.ch_idx  = ch_idx;
endmodule
